// File: rtl/auth_resp_arbiter.sv
// Round-robin arbiter sharing one authentication responder between ports A and B,
// with per-message-type millisecond timeouts. Define ARB_STRICT_PRIO_EN for fixed A-over-B priority.
module auth_resp_arbiter #(
  parameter int MSG_W      = 1000,
  parameter int DIGESTS_TO = 135,
  parameter int CERT_TO    = 135,
  parameter int CHAL_TO    = 635,
  parameter int DEFAULT_TO = 135,
  parameter int TO_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ms_tick,
  input  logic             req_a_valid,
  input  logic [MSG_W-1:0] req_a_msg,
  output logic             req_a_ready,
  output logic             rsp_a_valid,
  input  logic             rsp_a_ready,
  output logic [MSG_W-1:0] rsp_a_msg,
  output logic             rsp_a_err,
  input  logic             req_b_valid,
  input  logic [MSG_W-1:0] req_b_msg,
  output logic             req_b_ready,
  output logic             rsp_b_valid,
  input  logic             rsp_b_ready,
  output logic [MSG_W-1:0] rsp_b_msg,
  output logic             rsp_b_err,
  output logic             drv_req,
  output logic [MSG_W-1:0] drv_msg,
  input  logic             drv_rsp_valid,
  input  logic [MSG_W-1:0] drv_rsp_msg,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t           state;
  logic             last_b;
  logic             gnt_b;
  logic [TO_W-1:0]  to_cnt;
  logic             pick_a;
  logic             pick_b;
  logic [7:0]       gnt_type;
  logic [MSG_W-1:0] rsp_data;
  logic             rsp_err;
  logic             rsp_ready;

  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
`ifdef ARB_STRICT_PRIO_EN
    if (req_a_valid)      pick_a = 1'b1;
    else if (req_b_valid) pick_b = 1'b1;
`else
    // On contention A wins only if B was served last.
    if (req_a_valid && (!req_b_valid || last_b)) pick_a = 1'b1;
    else if (req_b_valid)                        pick_b = 1'b1;
`endif
  end

  assign gnt_type  = pick_b ? req_b_msg[15:8] : req_a_msg[15:8];
  // A responder answer always beats a same-cycle expiry.
  assign rsp_data  = drv_rsp_valid ? drv_rsp_msg : '0;
  assign rsp_err   = !drv_rsp_valid;
  assign rsp_ready = gnt_b ? rsp_b_ready : rsp_a_ready;
  assign busy      = (state != IDLE);

  function automatic logic [TO_W-1:0] load_to(input logic [7:0] msg_type);
    case (msg_type)
      8'd129:  return TO_W'(DIGESTS_TO);
      8'd130:  return TO_W'(CERT_TO);
      8'd131:  return TO_W'(CHAL_TO);
      default: return TO_W'(DEFAULT_TO);
    endcase
  endfunction

  // NOTE: all state and registered outputs update with non-blocking assignments so
  // every branch below reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      gnt_b       <= 1'b0;
      to_cnt      <= '0;
      req_a_ready <= 1'b0;
      req_b_ready <= 1'b0;
      rsp_a_valid <= 1'b0;
      rsp_a_msg   <= '0;
      rsp_a_err   <= 1'b0;
      rsp_b_valid <= 1'b0;
      rsp_b_msg   <= '0;
      rsp_b_err   <= 1'b0;
      drv_req     <= 1'b0;
      drv_msg     <= '0;
    end else begin
      req_a_ready <= 1'b0;
      req_b_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_a || pick_b) begin
            gnt_b       <= pick_b;
            drv_msg     <= pick_b ? req_b_msg : req_a_msg;
            req_a_ready <= pick_a;
            req_b_ready <= pick_b;
            to_cnt      <= load_to(gnt_type);
            drv_req     <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (drv_rsp_valid || to_cnt == '0) begin
            rsp_a_valid <= !gnt_b;
            rsp_a_msg   <= gnt_b ? '0 : rsp_data;
            rsp_a_err   <= !gnt_b && rsp_err;
            rsp_b_valid <= gnt_b;
            rsp_b_msg   <= gnt_b ? rsp_data : '0;
            rsp_b_err   <= gnt_b && rsp_err;
            drv_req     <= 1'b0;
            state       <= DELIVER;
          end else if (ms_tick) begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        DELIVER: begin
          if (rsp_ready) begin
            rsp_a_valid <= 1'b0;
            rsp_a_msg   <= '0;
            rsp_a_err   <= 1'b0;
            rsp_b_valid <= 1'b0;
            rsp_b_msg   <= '0;
            rsp_b_err   <= 1'b0;
            last_b      <= gnt_b;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/auth_resp_arbiter.md
Name: auth_resp_arbiter

Overview:
- Shares one authentication responder between two requester ports, A and B. Arbitration is round-robin.
- Forwards the granted request message to the responder and waits for its response.
- Enforces the per-message-type response timeouts in milliseconds. Returns either the response or a timeout error to the originating port.
- Sits between the port-level message sources and the responder, driving the responder's request/message inputs.

Parameters:
- MSG_W, 1000: message bus width in bits. Header is in bits [31:0]: byte0 ProtocolVersion, byte1 MessageType, byte2 Param1, byte3 Param2.
- DIGESTS_TO, 135: GET_DIGESTS (MessageType 129) timeout, in ms ticks.
- CERT_TO, 135: GET_CERTIFICATE (MessageType 130) timeout, in ms ticks.
- CHAL_TO, 635: CHALLENGE (MessageType 131) timeout, in ms ticks.
- DEFAULT_TO, 135: timeout for any other MessageType, in ms ticks.
- TO_W, 10: timeout counter width. Must hold the largest timeout value.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ms_tick  in  1  single-cycle pulse, once per millisecond
- req_a_valid  in  1  port A request pending
- req_a_msg  in  MSG_W  port A request message
- req_a_ready  out  1  one-cycle pulse: port A request accepted
- rsp_a_valid  out  1  port A response/error available
- rsp_a_ready  in  1  port A consumes response
- rsp_a_msg  out  MSG_W  port A response message
- rsp_a_err  out  1  port A response is a timeout, not responder data
- req_b_valid, req_b_msg, req_b_ready, rsp_b_valid, rsp_b_ready, rsp_b_msg, rsp_b_err: same as port A, for port B
- drv_req  out  1  request to responder; held high while waiting
- drv_msg  out  MSG_W  message to responder
- drv_rsp_valid  in  1  responder response strobe
- drv_rsp_msg  in  MSG_W  responder response message
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - State IDLE; last_grant = B, so A wins the first contest.
  - All outputs 0, including all message buses.
  - Reset in any state aborts the transaction. No response is delivered; the requester must re-request.
- State IDLE:
  - Both valid: grant the port opposite last_grant.
  - One valid: grant it.
  - Grant actions in the same edge: latch the message into drv_msg; pulse the granted req_x_ready for exactly 1 cycle; set gnt = granted port.
  - Load to_cnt from byte1 of the message: 129 -> DIGESTS_TO, 130 -> CERT_TO, 131 -> CHAL_TO, else DEFAULT_TO.
  - Go to WAIT.
- State WAIT:
  - drv_req = 1 and drv_msg stable throughout.
  - On each ms_tick with to_cnt != 0: to_cnt decrements by 1.
  - drv_rsp_valid: latch drv_rsp_msg into rsp_gnt_msg, err = 0, go to DELIVER.
  - Else, to_cnt == 0: rsp_gnt_msg = 0, err = 1, go to DELIVER.
  - drv_rsp_valid in the same cycle as expiry: the response wins, err = 0.
  - drv_req drops in the cycle DELIVER is entered.
- State DELIVER:
  - rsp_gnt_valid = 1; msg and err held stable until rsp_gnt_ready.
  - On the ready cycle, return to IDLE next cycle and set last_grant = gnt.
  - The non-granted port's rsp_valid stays 0.
  - Requests on either port are ignored (no ready) until back in IDLE.
- Latency:
  - Request accept to drv_req = 1: 1 cycle.
  - drv_rsp_valid to rsp_x_valid: 1 cycle.
  - rsp_x_ready to next possible grant: 1 cycle (IDLE).
- drv_rsp_valid outside WAIT is ignored.
- ms_tick outside WAIT has no effect.
- A request whose to_cnt loads as 0 (a parameter set to 0) times out on the first WAIT cycle unless the response is present that same cycle.

Optional Feature:
- Macro ARB_STRICT_PRIO_EN.
- Defined: port A always wins when both ports are valid. last_grant is still tracked but not used for selection.
- Undefined: round-robin as specified above.
- All other behaviour is identical.

Test Plan:
- Single A request, MessageType 130: A valid with byte1 = 130 -> req_a_ready pulse, drv_req = 1 next cycle, drv_msg = req_a_msg. Responder answers after 5 cycles -> rsp_a_valid = 1, rsp_a_err = 0, rsp_a_msg = responder data. rsp_b_valid stays 0.
- Contention: A and B valid together from reset -> A granted first. After A completes, B is granted. Then with both valid again -> A granted (alternation).
- Timeout, CHALLENGE: A request with byte1 = 131 and no responder response -> rsp_a_err = 1 after exactly 635 ms_ticks, rsp_a_msg = 0. A request with byte1 = 129 times out after 135 ticks.
- Expiry race: drv_rsp_valid in the same cycle to_cnt hits 0 -> err = 0 and response data is delivered.
- Backpressure and reset: hold rsp_b_ready = 0 for 20 cycles -> rsp_b_valid/msg/err stable and no new grant. Assert reset mid-WAIT -> all outputs 0, state IDLE, A wins the next contest.
- With ARB_STRICT_PRIO_EN defined: A and B continuously valid for 3 transactions -> all three granted to A.
